ex_muldiv_unit: RTL
===================

Name: ex_muldiv_unit

Overview:
Parametrised multi-cycle multiply/divide unit for the EX stage. It accepts one MULT/MULTU/DIV/DIVU request from EX and raises a stall request while it computes. It returns a HI/LO result pair for the HI/LO register path and holds that result until the pipeline acknowledges it. It replaces the ad-hoc mul/div start/stall glue in EX with a single FSM: a pipelined multiplier, a radix-2 restoring divider, annul support and a result-hold handshake.

Parameters:
DATA_W, 32, operand width; HI and LO are each DATA_W bits.
MUL_STAGES, 2, multiplier latency in cycles, legal range 1..4.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  1  EX holds a mul/div instruction
req_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
opa  in  DATA_W  rs operand (dividend / multiplicand)
opb  in  DATA_W  rt operand (divisor / multiplier)
annul  in  1  kill the in-flight operation (flush)
res_ack  in  1  pipeline advances past EX this cycle
stallreq  out  1  stall request to the stall controller
res_valid  out  1  result available
res_hi  out  DATA_W  product high half / remainder
res_lo  out  DATA_W  product low half / quotient
div_zero  out  1  last division had divisor 0

Behaviour:
- FSM states: IDLE, MUL, DIV, DONE.
- Reset: state IDLE; res_valid=0, res_hi=0, res_lo=0, div_zero=0, all counters 0.
- stallreq is combinational: 1 when (state==IDLE & req_valid & ~annul), or state==MUL, or state==DIV. It is 0 in DONE.
- IDLE, req_valid=1, annul=0: latch operands and op; go to MUL (op[1]=0) or DIV (op[1]=1).
  - Signed ops capture the absolute values plus the result signs.
  - div_zero is cleared on accept.
- MUL:
  - counter runs 0..MUL_STAGES-1; go to DONE when counter==MUL_STAGES-1.
  - res_valid first visible in cycle 1+MUL_STAGES, where the request cycle is 0.
- Multiply product: full 2*DATA_W. Signed = two's-complement product; {res_hi,res_lo}=product.
- DIV:
  - one quotient bit per cycle, DATA_W iterations; the final iteration writes sign-corrected results.
  - res_valid first visible in cycle DATA_W+1.
- Division sign rules: quotient sign = sign(opa)^sign(opb); remainder sign = sign(opa).
  - Signed MIN / -1 gives LO=MIN, HI=0 (wrap, no trap).
- Divisor 0: LO=all ones, HI=opa, div_zero=1. Same latency as a normal division unless the optional feature is enabled.
- DONE:
  - res_valid=1; res_hi, res_lo and div_zero are stable.
  - Stay in DONE while res_ack=0. req_valid staying high does NOT restart the unit.
  - res_ack=1 returns to IDLE next cycle. res_valid drops; result registers keep their values.
- annul has priority in every state:
  - IDLE: a request is not accepted.
  - MUL/DIV/DONE: go to IDLE next cycle; res_valid=0, no result is delivered.
  - stallreq is 0 in any cycle where annul=1.
- rst mid-operation behaves as full reset; the partial result is discarded.
- The multiplier pipeline must not leak a stale product: its valid bit is cleared by annul and by rst.

Optional Feature:
Macro MULDIV_EARLY_OUT_EN.
- Defined: on entering DIV, if divisor==0 or |opa| < |opb| (unsigned compare of absolute values), finish after one DIV cycle.
  - Results: quotient 0 and remainder opa (or the divisor-zero result), so res_valid appears in cycle 2.
- Undefined: every division takes the full DATA_W iterations. The comparator logic is absent.

Test Plan:
- MULTU opa=0xFFFFFFFF, opb=2, res_ack=1 -> stallreq high for cycles 0..2, res_valid in cycle 3, HI=0x00000001, LO=0xFFFFFFFE.
- MULT opa=-3, opb=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; then DIV opa=-7, opb=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, res_valid in cycle 33.
- DIVU opa=5, opb=0 -> LO=0xFFFFFFFF, HI=0x00000005, div_zero=1; with MULDIV_EARLY_OUT_EN, res_valid in cycle 2, otherwise cycle 33.
- DIV opa=0x80000000, opb=0xFFFFFFFF, res_ack held 0 for 3 cycles with req_valid=1 -> LO=0x80000000, HI=0; res_valid stays high with stable data, stallreq=0, no restart; IDLE the cycle after res_ack=1.
- DIVU started, annul pulsed in cycle 10 -> stallreq=0 in cycle 10, IDLE in cycle 11, res_valid never asserts; a MULTU 6*7 issued in cycle 11 gives LO=42, HI=0.
- rst asserted during MUL stage 1 -> all outputs 0 the next cycle, and no res_valid for the discarded product.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// EX-stage multi-cycle MULT/MULTU/DIV/DIVU unit: pipelined multiplier, radix-2 restoring divider, held HI/LO result.
// Optional MULDIV_EARLY_OUT_EN: single-cycle division when the divisor is 0 or |opa| < |opb|.
module ex_muldiv_unit #(
  parameter int DATA_W     = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  input  logic              annul,
  input  logic              res_ack,
  output logic              stallreq,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_hi,
  output logic [DATA_W-1:0] res_lo,
  output logic              div_zero
);
  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_STAGES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   opa_q, divb_q;
  logic [DATA_W-1:0]   rem_q, rem_d, quo_q, quo_d;
  logic                neg_q, rneg_q, dz_q;
  logic [DATA_W-1:0]   res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic                div_zero_q, div_zero_d;
  logic [2*DATA_W-1:0] pipe_q [MUL_STAGES];
  logic [MUL_STAGES-1:0] pvld_q;

  logic                sgn, a_neg, b_neg, accept;
  logic [DATA_W-1:0]   a_abs, b_abs;
  logic [2*DATA_W-1:0] mul_prod, mul_res;
  logic [DATA_W:0]     rem_sh, rem_diff;
  logic [DATA_W-1:0]   rem_n, quo_n;
  logic                div_last;

  assign sgn    = ~req_op[0];
  assign a_neg  = sgn & opa[DATA_W-1];
  assign b_neg  = sgn & opb[DATA_W-1];
  assign a_abs  = a_neg ? -opa : opa;
  assign b_abs  = b_neg ? -opb : opb;
  assign accept = (state_q == S_IDLE) & req_valid & ~annul;

  assign stallreq  = ~annul & (accept | (state_q == S_MUL) | (state_q == S_DIV));
  assign res_valid = (state_q == S_DONE);
  assign res_hi    = res_hi_q;
  assign res_lo    = res_lo_q;
  assign div_zero  = div_zero_q;

  // Magnitude product enters the pipe on accept; sign is applied on the way out.
  assign mul_prod = {{DATA_W{1'b0}}, a_abs} * {{DATA_W{1'b0}}, b_abs};
  assign mul_res  = neg_q ? -pipe_q[MUL_STAGES-1] : pipe_q[MUL_STAGES-1];

  assign rem_sh   = {rem_q, quo_q[DATA_W-1]};
  assign rem_diff = rem_sh - {1'b0, divb_q};
  assign rem_n    = rem_diff[DATA_W] ? rem_sh[DATA_W-1:0] : rem_diff[DATA_W-1:0];
  assign quo_n    = {quo_q[DATA_W-2:0], ~rem_diff[DATA_W]};

`ifdef MULDIV_EARLY_OUT_EN
  logic early_q;
  assign div_last = (cnt_q == DIV_LAST) | early_q;
`else
  assign div_last = (cnt_q == DIV_LAST);
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    res_hi_d   = res_hi_q;
    res_lo_d   = res_lo_q;
    div_zero_d = div_zero_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = req_op[1] ? S_DIV : S_MUL;
          cnt_d      = '0;
          rem_d      = '0;
          quo_d      = a_abs;
          div_zero_d = 1'b0;
        end
      end
      S_MUL: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == MUL_LAST) begin
          state_d = S_DONE;
          if (pvld_q[MUL_STAGES-1]) {res_hi_d, res_lo_d} = mul_res;
        end
      end
      S_DIV: begin
        cnt_d = cnt_q + CNT_ONE;
        rem_d = rem_n;
        quo_d = quo_n;
        if (div_last) begin
          state_d    = S_DONE;
          div_zero_d = dz_q;
          if (dz_q) begin
            res_hi_d = opa_q;
            res_lo_d = '1;
          end
`ifdef MULDIV_EARLY_OUT_EN
          else if (early_q) begin
            res_hi_d = opa_q;
            res_lo_d = '0;
          end
`endif
          else begin
            res_lo_d = neg_q  ? -quo_n : quo_n;
            res_hi_d = rneg_q ? -rem_n : rem_n;
          end
        end
      end
      S_DONE: begin
        if (res_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A flush discards the operation and leaves the previous result untouched.
    if (annul) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      res_hi_d   = res_hi_q;
      res_lo_d   = res_lo_q;
      div_zero_d = div_zero_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      opa_q      <= '0;
      divb_q     <= '0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      dz_q       <= 1'b0;
      res_hi_q   <= '0;
      res_lo_q   <= '0;
      div_zero_q <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
      early_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      res_hi_q   <= res_hi_d;
      res_lo_q   <= res_lo_d;
      div_zero_q <= div_zero_d;
      if (accept) begin
        opa_q   <= opa;
        divb_q  <= b_abs;
        neg_q   <= a_neg ^ b_neg;
        rneg_q  <= a_neg;
        dz_q    <= (opb == '0);
`ifdef MULDIV_EARLY_OUT_EN
        early_q <= (b_abs == '0) | (a_abs < b_abs);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || annul) begin
      pvld_q <= '0;
    end else begin
      pvld_q[0] <= accept & ~req_op[1];
      for (int i = 1; i < MUL_STAGES; i++) pvld_q[i] <= pvld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pipe_q[0] <= mul_prod;
    for (int i = 1; i < MUL_STAGES; i++) pipe_q[i] <= pipe_q[i-1];
  end
endmodule
